// File: rtl/chan_pkt_stb_sched.sv
// chan_pkt_stb_sched
// Packet-start strobe scheduler for the channelizer packet path.
// ctrl_reg = {period[31:16], burst[15:4], reserved[3:1], en[0]}.
// The enable is edge-armed: en must go 0->1 (as seen after one register
// stage) to latch period/burst and start a run. Strobes are issued every
// period+1 cycles, only on edges where pkt_ready=1, until burst strobes
// have been sent (burst=0 runs until en drops).
// Handshake: a strobe is issued on a rising edge only when pkt_ready=1.
// stb_out is the registered result and is high for the following cycle.
// Optional feature macro: CHAN_PKT_STB_MISS_CNT_EN adds the stall counter
// and the miss counter (status[23:12]). Without it, status[23:12] reads 0.
module chan_pkt_stb_sched #(
    parameter int PERIOD_W = 16,
    parameter int CNT_W    = 12
) (
    input  logic        user_clk,
    input  logic        user_rst_n,
    input  logic [31:0] ctrl_reg,
    input  logic        pkt_ready,
    output logic        stb_out,
    output logic        busy,
    output logic        done,
    output logic [31:0] status
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_STALL = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t                state, state_n;
    logic                  ctrl_en_q;
    logic [PERIOD_W-1:0]   ctrl_p_q;
    logic [CNT_W-1:0]      ctrl_n_q;
    logic                  en_q_d;
    logic [PERIOD_W-1:0]   period_q, period_n;
    logic [CNT_W-1:0]      burst_q, burst_n;
    logic [PERIOD_W-1:0]   cnt, cnt_n;
    logic [CNT_W-1:0]      sent_cnt, sent_n;
    logic [CNT_W-1:0]      sent_sat;
    logic                  issue;
    logic                  arm;
`ifdef CHAN_PKT_STB_MISS_CNT_EN
    logic [CNT_W-1:0]      miss_cnt, miss_n;
    logic [PERIOD_W-1:0]   stall_cnt, stall_n;
    logic [PERIOD_W-1:0]   stall_inc;
`endif

    // Reserved control bits carry no function.
    logic unused_rsvd;
    assign unused_rsvd = ^ctrl_reg[3:1];

    assign arm      = ctrl_en_q & ~en_q_d;
    assign sent_sat = (sent_cnt == CNT_MAX) ? sent_cnt : sent_cnt + 1'b1;
`ifdef CHAN_PKT_STB_MISS_CNT_EN
    assign stall_inc = stall_cnt + 1'b1;
`endif

    // Control word capture and enable edge history.
    always_ff @(posedge user_clk or negedge user_rst_n) begin
        if (!user_rst_n) begin
            ctrl_en_q <= 1'b0;
            ctrl_p_q  <= '0;
            ctrl_n_q  <= '0;
            en_q_d    <= 1'b0;
        end else begin
            ctrl_en_q <= ctrl_reg[0];
            ctrl_p_q  <= ctrl_reg[16 +: PERIOD_W];
            ctrl_n_q  <= ctrl_reg[4 +: CNT_W];
            en_q_d    <= ctrl_en_q;
        end
    end

    // Next-state and counter update logic; abort takes priority over issue.
    always_comb begin
        state_n  = state;
        period_n = period_q;
        burst_n  = burst_q;
        cnt_n    = cnt;
        sent_n   = sent_cnt;
        issue    = 1'b0;
`ifdef CHAN_PKT_STB_MISS_CNT_EN
        miss_n   = miss_cnt;
        stall_n  = stall_cnt;
`endif
        case (state)
            S_IDLE: begin
                if (arm) begin
                    period_n = ctrl_p_q;
                    burst_n  = ctrl_n_q;
                    sent_n   = '0;
                    cnt_n    = '0;
`ifdef CHAN_PKT_STB_MISS_CNT_EN
                    miss_n   = '0;
`endif
                    state_n  = S_WAIT;
                end
            end
            S_WAIT: begin
                if (!ctrl_en_q) begin
                    state_n = S_IDLE;
                end else if (cnt != '0) begin
                    cnt_n = cnt - 1'b1;
                end else if (pkt_ready) begin
                    issue = 1'b1;
                end else begin
                    state_n = S_STALL;
`ifdef CHAN_PKT_STB_MISS_CNT_EN
                    stall_n = '0;
`endif
                end
            end
            S_STALL: begin
                if (!ctrl_en_q) begin
                    state_n = S_IDLE;
                end else if (pkt_ready) begin
                    issue = 1'b1;
                end else begin
`ifdef CHAN_PKT_STB_MISS_CNT_EN
                    // One full period spent stalled counts as one missed slot.
                    if (stall_inc == period_q) begin
                        stall_n = '0;
                        if (miss_cnt != CNT_MAX) begin
                            miss_n = miss_cnt + 1'b1;
                        end
                    end else begin
                        stall_n = stall_inc;
                    end
`endif
                end
            end
            S_DONE: begin
                if (!ctrl_en_q) begin
                    state_n = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase

        if (issue) begin
            sent_n  = sent_sat;
            cnt_n   = period_q;
            state_n = ((burst_q != '0) && (sent_sat == burst_q)) ? S_DONE : S_WAIT;
        end
    end

    // State, counters and the strobe register.
    always_ff @(posedge user_clk or negedge user_rst_n) begin
        if (!user_rst_n) begin
            state     <= S_IDLE;
            period_q  <= '0;
            burst_q   <= '0;
            cnt       <= '0;
            sent_cnt  <= '0;
            stb_out   <= 1'b0;
`ifdef CHAN_PKT_STB_MISS_CNT_EN
            miss_cnt  <= '0;
            stall_cnt <= '0;
`endif
        end else begin
            state     <= state_n;
            period_q  <= period_n;
            burst_q   <= burst_n;
            cnt       <= cnt_n;
            sent_cnt  <= sent_n;
            stb_out   <= issue;
`ifdef CHAN_PKT_STB_MISS_CNT_EN
            miss_cnt  <= miss_n;
            stall_cnt <= stall_n;
`endif
        end
    end

    assign busy = (state == S_WAIT) || (state == S_STALL);
    assign done = (state == S_DONE);

    // Status word assembled purely from registered state.
    always_comb begin
        status          = '0;
        status[11:0]    = 12'(sent_cnt);
`ifdef CHAN_PKT_STB_MISS_CNT_EN
        status[23:12]   = 12'(miss_cnt);
`endif
        status[25:24]   = state;
    end

endmodule

// File: tb/tb_chan_pkt_stb_sched.sv
// Bench for chan_pkt_stb_sched: directed scenarios plus random traffic,
// checked against a transaction-level model of the scheduler rules.
module tb_chan_pkt_stb_sched;

  logic        user_clk = 1'b0;
  logic        user_rst_n;
  logic [31:0] ctrl_reg;
  logic        pkt_ready;
  logic        stb_out;
  logic        busy;
  logic        done;
  logic [31:0] status;

`ifdef CHAN_PKT_STB_MISS_CNT_EN
  localparam int MISS_BP_EXP  = 2;
  localparam int MISS_SAT_EXP = 4095;
`else
  localparam int MISS_BP_EXP  = 0;
  localparam int MISS_SAT_EXP = 0;
`endif

  chan_pkt_stb_sched dut (
    .user_clk   (user_clk),
    .user_rst_n (user_rst_n),
    .ctrl_reg   (ctrl_reg),
    .pkt_ready  (pkt_ready),
    .stb_out    (stb_out),
    .busy       (busy),
    .done       (done),
    .status     (status)
  );

  // clock / edge index
  always #5 user_clk = ~user_clk;

  int edge_cnt = 0;
  always @(posedge user_clk) edge_cnt <= edge_cnt + 1;

  // scoreboard
  logic [31:0] exp_q[$];
  logic [31:0] mon_exp;
  int checks = 0;
  int errors = 0;

  // reference model state
  int          m_mode;      // 0 idle, 1 running, 2 done
  logic [31:0] m_cq;        // control word as the design sees it
  logic        m_en_d;      // previous registered enable
  int          m_p, m_n, m_due, m_k, m_sent, m_miss;
  bit          m_stalled;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s edge=%0d got=%0h want=%0h", name, edge_cnt, got, want);
    end
  endtask

  function automatic logic [31:0] mk(input int p, input int n, input bit en);
    logic [15:0] pf;
    logic [11:0] nf;
    pf = p[15:0];
    nf = n[11:0];
    return {pf, nf, 3'b000, en};
  endfunction

  task automatic model_reset();
    m_mode = 0; m_cq = '0; m_en_d = 1'b0;
    m_p = 0; m_n = 0; m_due = 0; m_k = 0;
    m_sent = 0; m_miss = 0; m_stalled = 1'b0;
  endtask

  // Predict what the next rising edge does, from the current inputs.
  task automatic model_step();
    int   e;
    logic en;
    e  = edge_cnt + 1;
    en = m_cq[0];
    case (m_mode)
      0: if (en && !m_en_d) begin
        m_p = int'(m_cq[31:16]);
        m_n = int'(m_cq[15:4]);
        m_sent = 0; m_miss = 0;
        m_mode = 1; m_due = e + 1; m_stalled = 1'b0;
      end
      1: if (!en) begin
        m_mode = 0; m_stalled = 1'b0;
      end else if (e >= m_due) begin
        if (pkt_ready) begin
          exp_q.push_back(32'(e));
          if (m_sent < 4095) m_sent++;
          m_due = e + m_p + 1;
          m_stalled = 1'b0;
          if (m_n != 0 && m_sent == m_n) m_mode = 2;
        end else if (!m_stalled) begin
          m_stalled = 1'b1;
          m_k = 0;
        end else begin
          m_k++;
`ifdef CHAN_PKT_STB_MISS_CNT_EN
          if (m_p != 0 && (m_k % m_p) == 0 && m_miss < 4095) m_miss++;
`endif
        end
      end
      default: if (!en) m_mode = 0;
    endcase
    m_en_d = en;
    m_cq   = ctrl_reg;
  endtask

  task automatic check_outputs();
    int          st;
    logic [31:0] es;
    st = (m_mode == 0) ? 0 : (m_mode == 2) ? 3 : (m_stalled ? 2 : 1);
    es = 32'((st << 24) | (m_miss << 12) | m_sent);
    checks++;
    if ({busy, done, status} !== {(m_mode == 1), (m_mode == 2), es}) begin
      errors++;
      $display("FAIL outputs edge=%0d got busy=%0b done=%0b status=%h want busy=%0b done=%0b status=%h",
               edge_cnt, busy, done, status, (m_mode == 1), (m_mode == 2), es);
    end
  endtask

  // driver: apply inputs at the falling edge, predict, then check after the edge
  task automatic tick(input logic [31:0] c, input logic r);
    ctrl_reg  = c;
    pkt_ready = r;
    model_step();
    @(negedge user_clk);
    check_outputs();
  endtask

  // monitor: every strobe must match the next predicted strobe edge
  always @(negedge user_clk) begin
    if (stb_out === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL stb_unexpected edge=%0d got strobe want none", edge_cnt);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_exp != 32'(edge_cnt)) begin
          errors++;
          $display("FAIL stb_timing got edge=%0d want edge=%0d", edge_cnt, mon_exp);
        end
      end
    end else if (exp_q.size() != 0 && exp_q[0] < 32'(edge_cnt)) begin
      checks++;
      errors++;
      mon_exp = exp_q.pop_front();
      $display("FAIL stb_missing got none at edge=%0d want edge=%0d", edge_cnt, mon_exp);
    end
  end

  logic [31:0] cur;
  int          r;

  initial begin
    user_rst_n = 1'b0;
    ctrl_reg   = '0;
    pkt_ready  = 1'b0;
    model_reset();
    repeat (3) @(negedge user_clk);
    check("reset_status", status, 32'h0);
    check("reset_flags", {29'd0, stb_out, busy, done}, 32'h0);
    user_rst_n = 1'b1;
    repeat (4) tick('0, ($urandom_range(0, 1) == 1));

    // bounded burst: P=3, N=4
    cur = mk(3, 4, 1'b1);
    repeat (30) tick(cur, 1'b1);
    check("burst_sent", {20'd0, status[11:0]}, 32'd4);
    check("burst_done", {30'd0, busy, done}, 32'd1);
    repeat (3) tick('0, 1'b1);

    // back-pressure: N=0, P=9, ready low for 25 cycles at a strobe time
    cur = mk(9, 0, 1'b1);
    for (int g = 0; g < 100 && !(m_sent >= 1 && m_due == edge_cnt + 1); g++) tick(cur, 1'b1);
    repeat (25) tick(cur, 1'b0);
    tick(cur, 1'b1);
    check("bp_sent", {20'd0, status[11:0]}, 32'd2);
    check("bp_miss", {20'd0, status[23:12]}, 32'(MISS_BP_EXP));
    repeat (3) tick('0, 1'b1);

    // abort during WAIT with P=100
    cur = mk(100, 0, 1'b1);
    for (int g = 0; g < 20 && m_sent < 1; g++) tick(cur, 1'b1);
    repeat (20) tick(cur, 1'b1);
    repeat (150) tick(mk(100, 0, 1'b0), 1'b1);
    check("abort_sent_held", {20'd0, status[11:0]}, 32'd1);

    // abort landing on the edge where cnt=0 and ready=1
    cur = mk(5, 0, 1'b1);
    for (int g = 0; g < 40 && !(m_sent >= 1 && m_due == edge_cnt + 2); g++) tick(cur, 1'b1);
    repeat (10) tick(mk(5, 0, 1'b0), 1'b1);
    check("abort_edge_sent", {20'd0, status[11:0]}, 32'd1);

    // field change while busy is ignored; re-arm applies it
    cur = mk(5, 0, 1'b1);
    repeat (20) tick(cur, 1'b1);
    cur = mk(1, 0, 1'b1);
    repeat (20) tick(cur, 1'b1);
    tick(mk(1, 0, 1'b0), 1'b1);
    repeat (20) tick(cur, 1'b1);
    repeat (3) tick('0, 1'b1);

    // random traffic
    cur = mk($urandom_range(0, 6), $urandom_range(0, 5), 1'b0);
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 99);
      if (r < 2) cur[0] = ~cur[0];
      else if (r < 4) begin
        cur[31:16] = 16'($urandom_range(0, 6));
        cur[15:4]  = 12'($urandom_range(0, 5));
      end else if (r == 50) cur[3:1] = 3'($urandom_range(0, 7));
      tick(cur, ($urandom_range(0, 3) != 0));
    end
    repeat (3) tick('0, 1'b1);

    // sent counter saturation, continuous P=0
    cur = mk(0, 0, 1'b1);
    repeat (4200) tick(cur, 1'b1);
    check("sent_sat", {20'd0, status[11:0]}, 32'd4095);
    repeat (3) tick('0, 1'b1);

    // miss counter saturation, P=1 with ready held low
    cur = mk(1, 0, 1'b1);
    repeat (4200) tick(cur, 1'b0);
    check("miss_sat", {20'd0, status[23:12]}, 32'(MISS_SAT_EXP));
    check("stall_state", {30'd0, status[25:24]}, 32'd2);

    // asynchronous reset mid-STALL, release with en still high
    #2 user_rst_n = 1'b0;
    #1;
    check("async_rst_status", status, 32'h0);
    check("async_rst_flags", {29'd0, stb_out, busy, done}, 32'h0);
    model_reset();
    repeat (2) @(negedge user_clk);
    cur = mk(2, 3, 1'b1);
    ctrl_reg   = cur;
    user_rst_n = 1'b1;
    repeat (20) tick(cur, 1'b1);
    check("rearm_after_rst_sent", {20'd0, status[11:0]}, 32'd3);

    repeat (2) tick('0, 1'b1);
    check("pending_strobes", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/chan_pkt_stb_sched.md
# chan_pkt_stb_sched

Strobe scheduler for the channelizer packet path. Takes the quasi-static 32-bit software control word from the `stb_en` PPC-to-fabric register in the `user_clk` domain and issues single-cycle packet-start strobes to the packet builder. Strobes are issued at a programmed period, for a programmed burst length, and respect the builder's `pkt_ready` back-pressure. Exposes a 32-bit status word for a readback register.

## Interface
- `PERIOD_W`, default 16: period field width; fixed at ctrl_reg[31:16].
- `CNT_W`, default 12: burst, sent and miss counter width; burst field is ctrl_reg[15:4].
- `user_clk` in, 1: the only clock.
- `user_rst_n` in, 1: asynchronous, active-low reset.
- `ctrl_reg` in, 32: software control word, already in the `user_clk` domain.
  - [0] en
  - [3:1] reserved
  - [15:4] burst N; 0 means continuous
  - [31:16] period P
- `pkt_ready` in, 1: the builder can accept a strobe this cycle.
- `stb_out` out, 1: registered one-cycle packet-start strobe.
- `busy` out, 1: state is WAIT or STALL.
- `done` out, 1: state is DONE.
- `status` out, 32:
  - [11:0] sent_cnt
  - [23:12] miss_cnt
  - [25:24] state: IDLE=0, WAIT=1, STALL=2, DONE=3
  - [31:26] zero

## Operation
- **Control sampling.** `ctrl_reg` is registered once into ctrl_q. en_q_d holds the previous ctrl_q[0]. Arm condition: ctrl_q[0]=1 and en_q_d=0.
- **IDLE.** On arm:
  - latch P and N into internal registers;
  - clear sent_cnt and miss_cnt, and set the period counter to 0;
  - go to WAIT.
- **WAIT.**
  - If cnt≠0: decrement cnt.
  - If cnt=0 and pkt_ready=1: issue a strobe.
  - If cnt=0 and pkt_ready=0: go to STALL and clear the stall counter.
- **STALL.**
  - If pkt_ready=1: issue a strobe.
  - Otherwise increment the stall counter. When it reaches P, increment miss_cnt and clear the stall counter.
- **Issue a strobe.** All of the following happen on the same edge:
  - set stb_out to 1 for the next cycle;
  - increment sent_cnt;
  - reload cnt with P;
  - if N≠0 and the new sent_cnt equals N, go to DONE; otherwise go to WAIT.
- **DONE.** Hold. Go to IDLE when ctrl_q[0]=0.
- **Abort.** If ctrl_q[0]=0 in WAIT or STALL, go to IDLE on the next edge. No strobe is issued on that edge, even if pkt_ready=1. Abort has priority over issue.
- **Counters.** sent_cnt and miss_cnt hold their values in IDLE and DONE until the next arm.
  - Both saturate at 4095.
  - At saturation sent_cnt stays at 4095, so with N=0 strobes continue.
- **Re-arm.** Changes to P or N while busy are ignored. Changing them requires en 1→0→1.

## Timing
- **Reset.** `user_rst_n` low clears all of the following immediately and asynchronously:
  - state to IDLE;
  - stb_out, busy and done to 0;
  - status, ctrl_q, en_q_d, all counters and latched P/N to 0.
- **Reset release.** If ctrl_reg[0] is already 1 at release, this counts as a 0→1 edge and arms.
- **Arm latency.** ctrl_reg[0] rises before edge k:
  - ctrl_q updates at edge k;
  - WAIT is entered at edge k+1;
  - the strobe is issued at edge k+2;
  - stb_out is high in the cycle after edge k+2.
- **Strobe spacing.** With pkt_ready held high, consecutive stb_out pulses are exactly P+1 cycles apart. P=0 gives a strobe every cycle.
- **Handshake.** A strobe is issued only on an edge where pkt_ready=1. stb_out is never high for two cycles unless P=0.
- **Outputs.** stb_out, busy, done and status are registered with no combinational input-to-output paths. status.state reflects the current state.

## Configuration
- `CHAN_PKT_STB_MISS_CNT_EN` defined: the stall counter and miss_cnt are implemented as described.
- Not defined: both are removed, status[23:12] reads 0, and STALL behaviour is otherwise identical.

## Test plan
- **Reset values.** Hold reset, then release with ctrl_reg=0 → every output is 0 and state is IDLE.
- **Bounded burst.** ctrl_reg: P=3, N=4, en=1; pkt_ready=1 →
  - exactly 4 stb_out pulses, 4 cycles apart, the first 3 edges after the write;
  - then done=1, busy=0, sent_cnt=4.
- **Back-pressure.** N=0, P=9; pkt_ready low for 25 cycles at a strobe time → no strobe while low; strobe on the first ready edge.
  - miss_cnt=2 with `CHAN_PKT_STB_MISS_CNT_EN`.
  - miss_cnt=0 without it.
- **Abort.** Clear en during WAIT with P=100 → IDLE next edge, no further strobes, sent_cnt held.
  - Abort on the edge where ready=1 and cnt=0 → no strobe.
- **Re-arm and field changes.** While running with P=5, write P=1 with en=1 → spacing stays 6. Toggle en 0→1 → spacing becomes 2 and counters clear.
- **Reset mid-run.** Assert `user_rst_n` low mid-STALL → outputs clear asynchronously. After release with en still 1 → re-arms and the first strobe is 3 edges later.
